// File: rtl/key_gesture_decoder_if.sv
// ---------------------------------------------------------------------------
// key_gesture_decoder_if
//   Bundles the debounced key flags and the gesture pulses that pass between
//   the key debouncer, the gesture decoder and the time-setting logic.
//
//   Signals:
//     Key_P_flag    one-cycle debounced press pulse
//     Key_R_flag    one-cycle debounced release pulse
//     Short_pulse   one-cycle pulse: short press recognised
//     Double_pulse  one-cycle pulse: double press recognised
//     Long_pulse    one-cycle pulse: long press declared
//     Repeat_pulse  one-cycle pulse: auto-repeat tick while held
//     Hold          high while a long press is being held
//
//   Modports:
//     master  drives the key flags and observes the gesture outputs
//     slave   the decoder: consumes the key flags and drives the outputs
// ---------------------------------------------------------------------------
interface key_gesture_decoder_if;
    logic Key_P_flag;
    logic Key_R_flag;
    logic Short_pulse;
    logic Double_pulse;
    logic Long_pulse;
    logic Repeat_pulse;
    logic Hold;

    modport master (
        output Key_P_flag,
        output Key_R_flag,
        input  Short_pulse,
        input  Double_pulse,
        input  Long_pulse,
        input  Repeat_pulse,
        input  Hold
    );

    modport slave (
        input  Key_P_flag,
        input  Key_R_flag,
        output Short_pulse,
        output Double_pulse,
        output Long_pulse,
        output Repeat_pulse,
        output Hold
    );
endinterface

// File: rtl/key_gesture_decoder.sv
// ---------------------------------------------------------------------------
// key_gesture_decoder
//   Classifies debounced key activity into short, double and long presses and
//   produces auto-repeat ticks while a long press is held. Every class is a
//   registered one-cycle pulse so downstream logic never times presses itself.
//
//   Parameters:
//     LONG_CNT    cycles held before a long press is declared   (>= 2)
//     REPEAT_CNT  auto-repeat period while held                 (>= 2)
//     DOUBLE_WIN  window after a release for a second press     (>= 2)
//     CNT_W       counter width, must hold max(parameter) - 1
//
//   Ports:
//     Clk    system clock
//     Reset  asynchronous, active-high reset
//     bus    key_gesture_decoder_if.slave (key flags in, gesture pulses out)
// ---------------------------------------------------------------------------
module key_gesture_decoder #(
    parameter int LONG_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 10_000_000,
    parameter int DOUBLE_WIN = 15_000_000,
    parameter int CNT_W      = 30
) (
    input  logic                  Clk,
    input  logic                  Reset,
    key_gesture_decoder_if.slave  bus
);

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_LONG_HELD      = 3'd2;
    localparam logic [2:0] S_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd4;

    localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] C_DOUBLE_LAST = CNT_W'(DOUBLE_WIN - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_counting;
    logic             w_wrap;
    logic             w_short;
    logic             w_double;
    logic             w_long;
    logic             w_repeat;
    logic             r_short;
    logic             r_double;
    logic             r_long;
    logic             r_repeat;
    logic             r_hold;

    // Next-state and pulse triggers. Release is tested before the timeout in
    // PRESSED and LONG_HELD, and press before the timeout in WAIT_SECOND, so
    // the key flag wins whenever it coincides with a counter expiry.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_wrap      = 1'b0;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Key_P_flag) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if (bus.Key_R_flag) begin
                    w_state_nxt = S_WAIT_SECOND;
                end else if (r_cnt == C_LONG_LAST) begin
                    w_long      = 1'b1;
                    w_state_nxt = S_LONG_HELD;
                end
            end
            S_LONG_HELD: begin
                if (bus.Key_R_flag) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_REPEAT_LAST) begin
                    w_repeat = 1'b1;
                    w_wrap   = 1'b1;
                end
            end
            S_WAIT_SECOND: begin
                if (bus.Key_P_flag) begin
                    w_state_nxt = S_SECOND_PRESSED;
                end else if (r_cnt == C_DOUBLE_LAST) begin
                    w_short     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SECOND_PRESSED: begin
                // No long-press detection here, however long the key is held.
                if (bus.Key_R_flag) begin
                    w_double    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The counter times the current state only: it restarts on any state
    // change or repeat wrap, and idles at 0 in the untimed states.
    assign w_counting = (r_state == S_PRESSED) || (r_state == S_LONG_HELD) ||
                        (r_state == S_WAIT_SECOND);

    always_comb begin
        w_cnt_nxt = '0;
        if (w_counting && (w_state_nxt == r_state) && !w_wrap) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            // Decoded from the next state so Hold rises with Long_pulse.
            r_hold   <= (w_state_nxt == S_LONG_HELD);
        end
    end

    assign bus.Short_pulse  = r_short;
    assign bus.Double_pulse = r_double;
    assign bus.Long_pulse   = r_long;
    assign bus.Repeat_pulse = r_repeat;
    assign bus.Hold         = r_hold;

endmodule

// File: tb/tb_key_gesture_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_gesture_decoder
//   Drives key_gesture_decoder with the directed gestures listed for
//   LONG_CNT=20, REPEAT_CNT=5, DOUBLE_WIN=8, then with random gestures.
//   The expected outputs come from a timestamp-based gesture model: it
//   remembers when the press/release flags arrived and derives every pulse
//   from the elapsed cycle counts.
// ---------------------------------------------------------------------------
module tb_key_gesture_decoder;

    localparam int L  = 20;
    localparam int RP = 5;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    key_gesture_decoder_if bus ();

    key_gesture_decoder #(
        .LONG_CNT   (L),
        .REPEAT_CNT (RP),
        .DOUBLE_WIN (D),
        .CNT_W      (8)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Gesture model: flag timestamps, -1 when absent.
    int   m_press = -1;
    int   m_rel   = -1;
    int   m_sec   = -1;
    logic e_short, e_double, e_long, e_rep, e_hold;

    // Observed pulses per scenario: 0 short, 1 double, 2 long, 3 repeat, 4 hold.
    int p_cnt[5];
    int p_first[5];
    int p_last[5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_press  = -1;
        m_rel    = -1;
        m_sec    = -1;
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_rep    = 1'b0;
        e_hold   = 1'b0;
    endtask

    // Given the flags seen in cycle c, what the outputs must be in cycle c+1.
    task automatic model_step(input int c, input logic p, input logic r);
        int age;
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_rep    = 1'b0;
        if (m_press < 0) begin
            if (p) m_press = c;
        end else if (m_rel < 0) begin
            age = c - m_press;
            if (r) begin
                if (age <= L) m_rel = c;        // released before the long press was declared
                else          m_press = -1;     // end of a long hold: silent
            end else if (age == L) begin
                e_long = 1'b1;
            end else if (age > L && ((age - L) % RP) == 0) begin
                e_rep = 1'b1;
            end
        end else if (m_sec < 0) begin
            if (p) begin
                m_sec = c;
            end else if (c - m_rel == D) begin
                e_short = 1'b1;
                m_press = -1;
                m_rel   = -1;
            end
        end else if (r) begin
            e_double = 1'b1;
            m_press  = -1;
            m_rel    = -1;
            m_sec    = -1;
        end
        e_hold = (m_press >= 0) && (m_rel < 0) && (c - m_press >= L);
    endtask

    task automatic log_clear();
        for (int i = 0; i < 5; i++) begin
            p_cnt[i]   = 0;
            p_first[i] = -1;
            p_last[i]  = -1;
        end
    endtask

    task automatic log_bit(input int idx, input logic v);
        if (v) begin
            if (p_cnt[idx] == 0) p_first[idx] = cyc;
            p_last[idx] = cyc;
            p_cnt[idx]++;
        end
    endtask

    // One cycle: apply flags, compare on the falling edge, advance the model.
    task automatic tick(input logic p, input logic r, input logic rs);
        logic [4:0] act;
        logic [4:0] exp;
        bus.Key_P_flag = p;
        bus.Key_R_flag = r;
        rst            = rs;
        if (rs) model_clear();
        @(negedge clk);
        act = {bus.Short_pulse, bus.Double_pulse, bus.Long_pulse, bus.Repeat_pulse, bus.Hold};
        exp = {e_short, e_double, e_long, e_rep, e_hold};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL outputs cycle %0d: short/double/long/repeat/hold got %b, expected %b",
                     cyc, act, exp);
        end
        log_bit(0, act[4]);
        log_bit(1, act[3]);
        log_bit(2, act[2]);
        log_bit(3, act[1]);
        log_bit(4, act[0]);
        @(posedge clk);
        #1;
        if (!rs) model_step(cyc, p, r);
        cyc++;
    endtask

    // Directed gesture: flag cycles are relative to cycle 0, -1 = unused.
    task automatic play(input int len, input int pa, input int pb, input int ra, input int rb,
                        input int rs_a, input int rs_b);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        cyc = 0;
        log_clear();
        for (int c = 0; c < len; c++) begin
            tick(c == pa || c == pb, c == ra || c == rb, c >= rs_a && c <= rs_b);
        end
    endtask

    initial begin
        bus.Key_P_flag = 1'b0;
        bus.Key_R_flag = 1'b0;
        model_clear();
        log_clear();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b1);
        check("reset_hold", int'(bus.Hold), 0);
        check("reset_pulses", int'({bus.Short_pulse, bus.Double_pulse, bus.Long_pulse, bus.Repeat_pulse}), 0);

        // Short press
        play(20, 0, -1, 5, -1, -1, -1);
        check("short_cycle", p_last[0], 14);
        check("short_count", p_cnt[0], 1);
        check("short_others", p_cnt[1] + p_cnt[2] + p_cnt[3] + p_cnt[4], 0);

        // Double press
        play(25, 0, 9, 5, 12, -1, -1);
        check("double_cycle", p_last[1], 13);
        check("double_no_short", p_cnt[0], 0);

        // Long press with auto-repeat
        play(50, 0, -1, 40, -1, -1, -1);
        check("long_cycle", p_first[2], 21);
        check("repeat_count", p_cnt[3], 3);
        check("repeat_first", p_first[3], 26);
        check("repeat_last", p_last[3], 36);
        check("hold_first", p_first[4], 21);
        check("hold_last", p_last[4], 40);
        check("hold_len", p_cnt[4], 20);

        // Release coinciding with the long timeout takes the short path
        play(35, 0, -1, 20, -1, -1, -1);
        check("coincide_no_long", p_cnt[2], 0);
        check("coincide_short", p_last[0], 29);

        // Reset in the middle of a long hold
        play(60, 0, 40, 30, 42, 25, 26);
        check("rst_long_before", p_cnt[2], 1);
        check("rst_no_repeat", p_cnt[3], 0);
        check("rst_hold_last", p_last[4], 24);
        check("rst_short_count", p_cnt[0], 1);
        check("rst_short_cycle", p_last[0], 51);

        // Second press on the last window cycle
        play(25, 0, 13, 5, 15, -1, -1);
        check("win_last_double", p_last[1], 16);
        check("win_last_no_short", p_cnt[0], 0);

        // Second press one cycle too late: back-to-back short presses
        play(30, 0, 14, 5, 16, -1, -1);
        check("win_miss_short_count", p_cnt[0], 2);
        check("win_miss_short_first", p_first[0], 14);
        check("win_miss_short_last", p_last[0], 25);
        check("win_miss_no_double", p_cnt[1], 0);

        // Random gestures
        for (int g = 0; g < 80; g++) begin
            int idle_n;
            int hold_n;
            idle_n = int'($urandom_range(0, 10));
            for (int i = 0; i < idle_n; i++) tick(1'b0, $urandom_range(0, 3) == 0, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            hold_n = int'($urandom_range(1, 45));
            for (int i = 1; i < hold_n; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    tick(1'b0, 1'b0, 1'b1);
                    tick(1'b0, 1'b0, 1'b1);
                end else begin
                    tick($urandom_range(0, 4) == 0, 1'b0, 1'b0);
                end
            end
            tick($urandom_range(0, 5) == 0, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                idle_n = int'($urandom_range(0, D + 2));
                for (int i = 0; i < idle_n; i++) tick(1'b0, $urandom_range(0, 4) == 0, 1'b0);
                tick(1'b1, 1'b0, 1'b0);
                hold_n = int'($urandom_range(0, 30));
                for (int i = 0; i < hold_n; i++) tick($urandom_range(0, 4) == 0, 1'b0, 1'b0);
                tick(1'b0, 1'b1, 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 30; i++) begin
                    tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b0);
                end
            end
        end
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
